// File: rtl/seg_scan_ctrl.sv
// Avalon-MM 7-segment scan controller: per-digit pattern registers, one-hot digit walk with blanking gaps.
// Optional SEG_SCAN_DECODE_EN: digit regs hold {dp, hex nibble} and are decoded to segments at slot entry.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS    = 3,
  parameter int PRESCALE      = 50000,
  parameter int BLANK_CYCLES  = 16,
  parameter int EN_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [NUM_DIGITS-1:0] seg_en,
  output logic [7:0]            seg_data
);

`ifdef SEG_SCAN_DECODE_EN
  localparam int DW = 5;
`else
  localparam int DW = 8;
`endif

  localparam int CMAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] PRE_LD = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLK_LD = CW'(BLANK_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] EN_OFF = {NUM_DIGITS{EN_ACTIVE_LOW != 0}};
  localparam logic [1:0] IDX_LAST = 2'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_ON} state_t;

  state_t                state_q, state_d;
  logic [DW-1:0]         digit_q [NUM_DIGITS];
  logic                  run_q;
  logic [2:0]            mask_q;
  logic [1:0]            idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic [7:0]            seg_q, seg_d;

  logic                  wr;
  logic [DW-1:0]         cur_digit;
  logic [NUM_DIGITS-1:0] onehot;
  logic [NUM_DIGITS-1:0] en_lit;
  logic                  unused_wdata;

  assign wr           = chipselect && !write_n;
  assign unused_wdata = ^writedata[31:DW];

  function automatic logic [6:0] hex7seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] seg_pattern(input logic [DW-1:0] d);
`ifdef SEG_SCAN_DECODE_EN
    return {d[4], hex7seg(d[3:0])};
`else
    return d;
`endif
  endfunction

  // Register file: writes to digit addresses beyond NUM_DIGITS fall through untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= '0;
      run_q  <= 1'b0;
      mask_q <= 3'b000;
    end else if (wr) begin
      for (int i = 0; i < NUM_DIGITS; i++)
        if (address == 2'(i)) digit_q[i] <= writedata[DW-1:0];
      if (address == 2'd3) begin
        run_q  <= writedata[0];
        mask_q <= writedata[3:1];
      end
    end
  end

  always_comb begin
    readdata = 32'h0;
    if (address == 2'd3) begin
      readdata = {26'h0, idx_q, mask_q, run_q};
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++)
        if (address == 2'(i)) readdata = 32'(digit_q[i]);
    end
  end

  always_comb begin
    cur_digit = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (idx_q == 2'(i)) cur_digit = digit_q[i];
  end

  assign onehot = NUM_DIGITS'(1) << idx_q;
  assign en_lit = (EN_ACTIVE_LOW != 0) ? ~onehot : onehot;

  // state   | meaning
  // S_IDLE  | scan stopped, all enables off, idx parked at 0
  // S_BLANK | inter-digit gap, enables off, down-counting BLANK_CYCLES
  // S_ON    | digit idx lit (unless masked), down-counting PRESCALE
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    seg_d   = seg_q;
    case (state_q)
      S_IDLE: begin
        en_d  = EN_OFF;
        idx_d = 2'd0;
        if (run_q) begin
          state_d = S_BLANK;
          cnt_d   = BLK_LD;
        end
      end
      S_BLANK: begin
        if (!run_q) begin
          state_d = S_IDLE;
          idx_d   = 2'd0;
          cnt_d   = '0;
          en_d    = EN_OFF;
        end else if (cnt_q == '0) begin
          state_d = S_ON;
          cnt_d   = PRE_LD;
          seg_d   = seg_pattern(cur_digit);
          en_d    = mask_q[idx_q] ? en_lit : EN_OFF;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_ON: begin
        if (!run_q) begin
          state_d = S_IDLE;
          idx_d   = 2'd0;
          cnt_d   = '0;
          en_d    = EN_OFF;
        end else if (cnt_q == '0) begin
          state_d = S_BLANK;
          cnt_d   = BLK_LD;
          en_d    = EN_OFF;
          idx_d   = (idx_q == IDX_LAST) ? 2'd0 : idx_q + 2'd1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        en_d    = EN_OFF;
        idx_d   = 2'd0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      en_q    <= EN_OFF;
      seg_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      seg_q   <= seg_d;
    end
  end

  assign seg_en   = en_q;
  assign seg_data = seg_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: time-indexed scan model checked every cycle plus literal spot checks.
module tb_seg_scan_ctrl;
  localparam int P  = 4;
  localparam int B  = 2;
  localparam int N  = 3;
  localparam int SL = P + B;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  address = 2'd3;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic [2:0]  seg_en;
  logic [7:0]  seg_data;

  int n_vec = 0;
  int n_err = 0;
  bit chk = 1'b0;

  seg_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(B), .EN_ACTIVE_LOW(1)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .seg_en(seg_en), .seg_data(seg_data)
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model: scan position is a plain cycle count since the scan started.
  logic [7:0] m_dig [3];
  logic       m_run;
  logic [2:0] m_mask;
  logic       m_act;
  int         m_tick;
  logic [7:0] m_seg;
  logic [2:0] m_en;

  function automatic logic [7:0] m_store(input logic [31:0] wd);
`ifdef SEG_SCAN_DECODE_EN
    return {3'b000, wd[4:0]};
`else
    return wd[7:0];
`endif
  endfunction

  function automatic logic [7:0] m_pat(input logic [7:0] d);
`ifdef SEG_SCAN_DECODE_EN
    return {d[4], hex_tab[d[3:0]]};
`else
    return d;
`endif
  endfunction

  function automatic int m_idx();
    return m_act ? (m_tick / SL) % N : 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    logic [1:0] ix;
    ix = 2'(m_idx());
    if (a == 2'd3) return {26'h0, ix, m_mask, m_run};
    return {24'h0, m_dig[a]};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    int t;
    int sl;
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) m_dig[i] <= 8'h00;
      m_run <= 1'b0; m_mask <= 3'b000; m_act <= 1'b0; m_tick <= 0;
      m_seg <= 8'h00; m_en <= 3'b111;
    end else begin
      if (chipselect && !write_n) begin
        if (address == 2'd3) begin
          m_run  <= writedata[0];
          m_mask <= writedata[3:1];
        end else begin
          m_dig[address] <= m_store(writedata);
        end
      end
      if (m_act && !m_run) begin
        m_act <= 1'b0; m_tick <= 0; m_en <= 3'b111;
      end else if (!m_act && m_run) begin
        m_act <= 1'b1; m_tick <= 0;
      end else if (m_act) begin
        t  = m_tick + 1;
        sl = (t / SL) % N;
        m_tick <= t;
        if (t % SL == B) begin
          m_seg <= m_pat(m_dig[sl]);
          m_en  <= m_mask[sl] ? ~(3'b001 << sl) : 3'b111;
        end else if (t % SL == 0) begin
          m_en <= 3'b111;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk) begin
      n_vec++;
      if (seg_en !== m_en || seg_data !== m_seg || readdata !== m_read(address)) begin
        n_err++;
        $display("FAIL scan t=%0t seg_en=%b exp %b seg_data=%h exp %h readdata=%h exp %h",
                 $time, seg_en, m_en, seg_data, m_seg, readdata, m_read(address));
      end
      n_vec++;
      if ($countones(~seg_en) > 1) begin
        n_err++;
        $display("FAIL onehot t=%0t seg_en=%b required at most one active", $time, seg_en);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got %h required %h", nm, $time, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  // Waits for the start of a slot showing pattern v; returns at a falling edge inside it.
  task automatic wait_start(input logic [2:0] v, input string nm);
    bit left;
    bit found;
    left = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (seg_en != v) left = 1'b1;
      else if (left) found = 1'b1;
    end
    if (!found) begin
      n_vec++; n_err++;
      $display("FAIL %s timeout seg_en=%b required %b", nm, seg_en, v);
    end
  endtask

  initial begin
    int c110, c101, c011, c111;
    #1 reset_n = 1'b0;
    chk = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1 check("reset_ctrl", readdata, 32'h0);
    repeat (20) @(negedge clk);
    check("reset_en", 32'(seg_en), 32'h7);
    check("reset_seg", 32'(seg_data), 32'h0);

    wr(2'd0, 32'h3F); wr(2'd1, 32'h06); wr(2'd2, 32'h5B);
    address = 2'd1; #1 check("read_dig1", readdata, 32'h06);
    wr(2'd3, 32'hF);
    @(posedge clk); #1 check("start_blank1", 32'(seg_en), 32'h7);
    @(posedge clk); #1 check("start_blank2", 32'(seg_en), 32'h7);
    @(posedge clk); #1 check("first_lit", 32'(seg_en), 32'h6);
    check("first_seg", 32'(seg_data), 32'h3F);
    c110 = 0; c101 = 0; c011 = 0; c111 = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      case (seg_en)
        3'b110: c110++;
        3'b101: c101++;
        3'b011: c011++;
        3'b111: c111++;
        default: ;
      endcase
    end
    check("period_d0", 32'(c110), 32'd4);
    check("period_d1", 32'(c101), 32'd4);
    check("period_d2", 32'(c011), 32'd4);
    check("period_blank", 32'(c111), 32'd6);
    address = 2'd3;
    wait_start(3'b011, "wait_d2");
    check("idx_read", 32'(readdata[5:4]), 32'd2);
    check("d2_seg", 32'(seg_data), 32'h5B);

    wr(2'd3, 32'hB);
    wait_start(3'b110, "wait_mask");
    c110 = 0; c101 = 0;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      if (seg_en == 3'b110) c110++;
      if (seg_en == 3'b101) c101++;
    end
    check("masked_d1", 32'(c101), 32'd0);
    check("masked_d0_cnt", 32'(c110), 32'd8);

    wait_start(3'b110, "wait_d0_upd");
    wr(2'd0, 32'h7F);
    check("midslot_en", 32'(seg_en), 32'h6);
    check("midslot_seg", 32'(seg_data), 32'h3F);
    wait_start(3'b110, "wait_d0_next");
    check("nextslot_seg", 32'(seg_data), 32'h7F);

    wait_start(3'b011, "wait_d2_stop");
    wr(2'd3, 32'h0);
    @(posedge clk); #1 check("stop_en", 32'(seg_en), 32'h7);
    check("stop_ctrl", readdata, 32'h0);
    check("stop_seg_held", 32'(seg_data), 32'h5B);
    repeat (3) @(negedge clk);
    wr(2'd3, 32'hF);
    @(posedge clk); #1 check("restart_b1", 32'(seg_en), 32'h7);
    @(posedge clk); #1 check("restart_b2", 32'(seg_en), 32'h7);
    @(posedge clk); #1 check("restart_lit", 32'(seg_en), 32'h6);
    check("restart_seg", 32'(seg_data), 32'h7F);

    wait_start(3'b101, "wait_d1_rst");
    address = 2'd0;
    #2 reset_n = 1'b0;
    #1 check("arst_en", 32'(seg_en), 32'h7);
    check("arst_seg", 32'(seg_data), 32'h0);
    check("arst_reg", readdata, 32'h0);
    @(posedge clk); #1 reset_n = 1'b1;
`ifdef SEG_SCAN_DECODE_EN
    wr(2'd0, 32'h18);
    wr(2'd3, 32'h3);
    wait_start(3'b110, "wait_dec");
    check("decode_seg", 32'(seg_data), 32'hFF);
`else
    wr(2'd3, 32'h3);
    wait_start(3'b110, "wait_post_rst");
    check("post_rst_seg", 32'(seg_data), 32'h00);
`endif
    repeat (20) @(negedge clk);
    chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
